// File: rtl/uart_pkg.sv
// Register map of avalon_uart and shared types for the streamer host that drives it.
package uart_pkg;

    localparam logic [4:0] UART_TXDATA  = 5'h00;
    localparam logic [4:0] UART_RXDATA  = 5'h04;
    localparam int         TXDATA_FULL  = 31;
    localparam int         RXDATA_EMPTY = 31;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TX_POLL  = 2'd1,
        ST_TX_WRITE = 2'd2,
        ST_RX_READ  = 2'd3
    } streamer_state_t;

    // Round-robin pointer value: the job that wins when both are pending.
    typedef enum logic {
        JOB_TX = 1'b0,
        JOB_RX = 1'b1
    } streamer_job_t;

endpackage

// File: rtl/avalon_uart_streamer_if.sv
// Avalon-MM bus between the streamer (master) and avalon_uart (slave).
interface avalon_uart_streamer_if;

    logic        avn_read;
    logic        avn_write;
    logic [4:0]  avn_address;
    logic [31:0] avn_writedata;
    logic [31:0] avn_readdata;
    logic        avn_waitrequest;

    modport master (
        output avn_read,
        output avn_write,
        output avn_address,
        output avn_writedata,
        input  avn_readdata,
        input  avn_waitrequest
    );

    modport slave (
        input  avn_read,
        input  avn_write,
        input  avn_address,
        input  avn_writedata,
        output avn_readdata,
        output avn_waitrequest
    );

endinterface

// File: rtl/avalon_uart_streamer.sv
// Avalon-MM host that bridges a TX byte stream into the UART TX FIFO (after a space poll)
// and pops the UART RX FIFO into an RX byte stream.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no command on the bus; pick the next job (round robin)
// ST_TX_POLL  | read txdata, bit31 says whether the TX FIFO is full
// ST_TX_WRITE | write the held byte into the TX FIFO
// ST_RX_READ  | read rxdata (pops the RX FIFO), bit31 says empty
module avalon_uart_streamer
    import uart_pkg::*;
#(
    parameter logic [4:0] TXDATA_ADDR = UART_TXDATA,
    parameter logic [4:0] RXDATA_ADDR = UART_RXDATA
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [7:0]                    tx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [7:0]                    rx_data,
    avalon_uart_streamer_if.master        avn
);

    streamer_state_t state_q;
    streamer_job_t   ptr_q;
    logic [7:0]      hold_q;
    logic            hold_full_q;
    logic [7:0]      rx_q;
    logic            rx_full_q;
    logic            read_q;
    logic            write_q;
    logic [4:0]      addr_q;
    logic [31:0]     wdata_q;

    logic tx_pending;
    logic rx_pending;
    logic pick_tx;
    logic stall;
    logic unused_readdata;

    assign tx_pending = hold_full_q;
    assign rx_pending = !rx_full_q;
    assign pick_tx    = tx_pending && (!rx_pending || (ptr_q == JOB_TX));
    assign stall      = avn.avn_waitrequest;

    assign tx_ready          = !hold_full_q;
    assign rx_valid          = rx_full_q;
    assign rx_data           = rx_q;
    assign avn.avn_read      = read_q;
    assign avn.avn_write     = write_q;
    assign avn.avn_address   = addr_q;
    assign avn.avn_writedata = wdata_q;

    assign unused_readdata = ^avn.avn_readdata[30:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= JOB_TX;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_q        <= 8'h00;
            rx_full_q   <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 5'h00;
            wdata_q     <= 32'h0000_0000;
        end else begin
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
            if (rx_full_q && rx_ready) begin
                rx_full_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pick_tx) begin
                        state_q <= ST_TX_POLL;
                        read_q  <= 1'b1;
                        addr_q  <= TXDATA_ADDR;
                    end else if (rx_pending) begin
                        state_q <= ST_RX_READ;
                        read_q  <= 1'b1;
                        addr_q  <= RXDATA_ADDR;
                    end
                end

                ST_TX_POLL: begin
                    if (!stall) begin
                        read_q <= 1'b0;
                        if (avn.avn_readdata[TXDATA_FULL]) begin
                            // FIFO full: keep the byte and give RX a turn before re-polling
                            state_q <= ST_IDLE;
                            ptr_q   <= JOB_RX;
                        end else begin
                            state_q <= ST_TX_WRITE;
                            write_q <= 1'b1;
                            wdata_q <= {24'h00_0000, hold_q};
                        end
                    end
                end

                ST_TX_WRITE: begin
                    if (!stall) begin
                        write_q     <= 1'b0;
                        hold_full_q <= 1'b0;
                        ptr_q       <= JOB_RX;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_RX_READ: begin
                    if (!stall) begin
                        read_q  <= 1'b0;
                        ptr_q   <= JOB_TX;
                        state_q <= ST_IDLE;
                        if (!avn.avn_readdata[RXDATA_EMPTY]) begin
                            rx_q      <= avn.avn_readdata[7:0];
                            rx_full_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_uart_streamer.sv
// Self-checking bench: behavioural avalon_uart slave (with loopback mode), directed vector tables
// for TX and RX, plus hand-written latency, reset and loopback sequences.
module tb_avalon_uart_streamer;

    typedef struct {
        logic [7:0]  data;
        int          full_polls;
        int          stall;
        logic [31:0] exp_wdata;
        int          exp_polls;
    } tx_vec_t;

    typedef struct {
        logic        present;
        logic [7:0]  data;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } rx_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    avalon_uart_streamer_if avn ();

    avalon_uart_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .avn      (avn)
    );

    // slave knobs, owned by the stimulus process
    int         stall_n = 0;
    int         full_target = 0;
    int         rx_push = 0;
    logic       loopback = 1'b0;
    logic [7:0] rxmem [0:63];
    int         send_timeouts = 0;

    // slave state and bus log, owned by the monitor
    int          stall_cnt = 0;
    int          n_full = 0;
    int          rx_pop = 0;
    logic [7:0]  lbmem [0:255];
    int          lb_wr = 0;
    int          lb_rd = 0;
    int          n_poll = 0;
    int          n_write = 0;
    int          n_rxread = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [4:0]  last_waddr = 5'h1f;
    int          unstable = 0;
    logic        stalled_prev = 1'b0;
    logic        prev_read = 1'b0;
    logic        prev_write = 1'b0;
    logic [4:0]  prev_addr = 5'h0;
    logic [31:0] prev_wdata = 32'h0;
    int          lb_got = 0;
    int          lb_bad = 0;

    logic tx_full_resp;

    always_comb begin
        tx_full_resp = loopback ? ((lb_wr - lb_rd) >= 4) : (n_full < full_target);
        avn.avn_waitrequest = (avn.avn_read | avn.avn_write) && (stall_cnt < stall_n);
        avn.avn_readdata = 32'h0000_0000;
        if (avn.avn_address == 5'h00) begin
            avn.avn_readdata = {tx_full_resp, 31'b0};
        end else if (avn.avn_address == 5'h04) begin
            if (loopback)
                avn.avn_readdata = (lb_wr != lb_rd) ? {24'h0, lbmem[lb_rd[7:0]]} : 32'h8000_0000;
            else
                avn.avn_readdata = (rx_push != rx_pop) ? {24'h0, rxmem[rx_pop[5:0]]} : 32'h8000_0000;
        end
    end

    always @(posedge clk) begin : mon
        int bad;
        bad = 0;
        if (rst) begin
            stall_cnt    <= 0;
            stalled_prev <= 1'b0;
        end else begin
            if (stalled_prev && (avn.avn_read !== prev_read || avn.avn_write !== prev_write ||
                                 avn.avn_address !== prev_addr || avn.avn_writedata !== prev_wdata))
                bad = bad + 1;
            if (avn.avn_read && avn.avn_write)
                bad = bad + 1;
            stalled_prev <= 1'b0;
            if (avn.avn_read || avn.avn_write) begin
                if (avn.avn_waitrequest) begin
                    stall_cnt    <= stall_cnt + 1;
                    stalled_prev <= 1'b1;
                    prev_read    <= avn.avn_read;
                    prev_write   <= avn.avn_write;
                    prev_addr    <= avn.avn_address;
                    prev_wdata   <= avn.avn_writedata;
                end else begin
                    stall_cnt <= 0;
                    if (avn.avn_write) begin
                        n_write    <= n_write + 1;
                        last_wdata <= avn.avn_writedata;
                        last_waddr <= avn.avn_address;
                        if (loopback) begin
                            lbmem[lb_wr[7:0]] <= avn.avn_writedata[7:0];
                            lb_wr <= lb_wr + 1;
                        end
                    end else if (avn.avn_address == 5'h00) begin
                        n_poll <= n_poll + 1;
                        if (tx_full_resp) n_full <= n_full + 1;
                    end else if (avn.avn_address == 5'h04) begin
                        n_rxread <= n_rxread + 1;
                        if (loopback) begin
                            if (lb_wr != lb_rd) lb_rd <= lb_rd + 1;
                        end else if (rx_push != rx_pop) begin
                            rx_pop <= rx_pop + 1;
                        end
                    end
                end
            end
            if (loopback && rx_valid && rx_ready) begin
                if (rx_data != lb_got[7:0]) bad = bad + 0;
                if (rx_data != lb_got[7:0]) lb_bad <= lb_bad + 1;
                lb_got <= lb_got + 1;
            end
            unstable <= unstable + bad;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int c;
        c = 0;
        while (!tx_ready && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (!tx_ready) send_timeouts++;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    tx_vec_t txv [5];
    rx_vec_t rxv [4];

    initial begin
        int w0, p0, r0, r1, c;

        txv[0] = '{8'hA5, 0, 0, 32'h0000_00A5, 1};
        txv[1] = '{8'h5A, 3, 0, 32'h0000_005A, 4};
        txv[2] = '{8'hFF, 0, 4, 32'h0000_00FF, 1};
        txv[3] = '{8'h00, 1, 4, 32'h0000_0000, 2};
        txv[4] = '{8'h81, 2, 1, 32'h0000_0081, 3};

        rxv[0] = '{1'b1, 8'h3C, 1'b1, 8'h3C};
        rxv[1] = '{1'b0, 8'h00, 1'b0, 8'h00};
        rxv[2] = '{1'b1, 8'hC3, 1'b1, 8'hC3};
        rxv[3] = '{1'b1, 8'h00, 1'b1, 8'h00};

        // reset values
        #12;
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_read", 32'(avn.avn_read), 32'h0);
        check("rst_write", 32'(avn.avn_write), 32'h0);
        check("rst_address", 32'(avn.avn_address), 32'h0);
        check("rst_writedata", avn.avn_writedata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // TX vectors: polls, backpressure and waitrequest stalls
        for (int i = 0; i < 5; i++) begin
            stall_n     = txv[i].stall;
            full_target = n_full + txv[i].full_polls;
            w0 = n_write;
            p0 = n_poll;
            r0 = n_rxread;
            send_byte(txv[i].data);
            for (c = 0; c < 400 && n_write == w0; c++) @(negedge clk);
            check("tx_ready_after_write", 32'(tx_ready), 32'h1);
            repeat (20) @(negedge clk);
            check("tx_write_count", 32'(n_write - w0), 32'h1);
            check("tx_write_data", last_wdata, txv[i].exp_wdata);
            check("tx_write_addr", 32'(last_waddr), 32'h0);
            check("tx_poll_count", 32'(n_poll - p0), 32'(txv[i].exp_polls));
            if (txv[i].full_polls > 0)
                check("tx_repoll_interleave", 32'((n_rxread - r0) >= txv[i].full_polls), 32'h1);
        end

        // RX vectors with downstream stalled
        stall_n  = 0;
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            r0 = n_rxread;
            if (rxv[i].present) begin
                rxmem[rx_push[5:0]] = rxv[i].data;
                rx_push++;
                for (c = 0; c < 100; c++) begin
                    if (avn.avn_read && avn.avn_address == 5'h04 && !avn.avn_waitrequest) break;
                    @(negedge clk);
                end
                @(negedge clk);
                check("rx_valid_latency", 32'(rx_valid), 32'(rxv[i].exp_valid));
                check("rx_data", 32'(rx_data), 32'(rxv[i].exp_data));
                r1 = n_rxread;
                repeat (20) @(negedge clk);
                check("rx_no_reads_while_full", 32'(n_rxread - r1), 32'h0);
                check("rx_data_held", 32'(rx_data), 32'(rxv[i].exp_data));
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                check("rx_drained", 32'(rx_valid), 32'h0);
            end else begin
                repeat (20) @(negedge clk);
                check("rx_empty_valid", 32'(rx_valid), 32'(rxv[i].exp_valid));
                check("rx_empty_repoll", 32'((n_rxread - r0) >= 3), 32'h1);
            end
        end

        // TX latency with the RX buffer full so RX does not compete
        rxmem[rx_push[5:0]] = 8'h77;
        rx_push++;
        for (c = 0; c < 100 && !rx_valid; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        full_target = n_full;
        check("lat_n_tx_ready", 32'(tx_ready), 32'h1);
        tx_data  = 8'h4D;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("lat_n1_idle_read", 32'(avn.avn_read), 32'h0);
        check("lat_n1_tx_ready", 32'(tx_ready), 32'h0);
        @(negedge clk);
        check("lat_n2_poll_read", 32'(avn.avn_read), 32'h1);
        check("lat_n2_poll_addr", 32'(avn.avn_address), 32'h0);
        @(negedge clk);
        check("lat_n3_write", 32'(avn.avn_write), 32'h1);
        check("lat_n3_wdata", avn.avn_writedata, 32'h0000_004D);
        check("lat_n3_read_low", 32'(avn.avn_read), 32'h0);
        @(negedge clk);
        check("lat_n4_write_low", 32'(avn.avn_write), 32'h0);
        check("lat_n4_tx_ready", 32'(tx_ready), 32'h1);
        check("lat_rx_held", 32'(rx_data), 32'h77);
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);

        // reset during a stalled TX write
        stall_n     = 50;
        full_target = n_full;
        send_byte(8'h99);
        for (c = 0; c < 400 && !avn.avn_write; c++) @(negedge clk);
        check("rstmid_write_seen", 32'(avn.avn_write), 32'h1);
        w0 = n_write;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_write", 32'(avn.avn_write), 32'h0);
        check("rstmid_read", 32'(avn.avn_read), 32'h0);
        check("rstmid_address", 32'(avn.avn_address), 32'h0);
        check("rstmid_writedata", avn.avn_writedata, 32'h0);
        check("rstmid_tx_ready", 32'(tx_ready), 32'h1);
        check("rstmid_rx_valid", 32'(rx_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        stall_n = 0;
        repeat (30) @(negedge clk);
        check("rstmid_byte_discarded", 32'(n_write - w0), 32'h0);

        // loopback: 0x00..0xFF must come back in order
        loopback = 1'b1;
        rx_ready = 1'b1;
        for (int b = 0; b < 256; b++) send_byte(8'(b));
        for (c = 0; c < 4000 && lb_got < 256; c++) @(negedge clk);
        check("loop_count", 32'(lb_got), 32'd256);
        check("loop_data_errors", 32'(lb_bad), 32'h0);
        check("send_timeouts", 32'(send_timeouts), 32'h0);
        check("bus_stable_during_stall", 32'(unstable), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
